// File: rtl/pipe_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencing logic.
// Contents:
//   op_type_e  - decoder op codes for MULT/MULTU/DIV/DIVU
//   state_e    - controller FSM encodings
//   HILO_SEL_* - write-back mux select codes for HI/LO
//   op_is_div / op_is_signed - op classification helpers
package pipe_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] HILO_SEL_DIV = 2'd0;
    localparam logic [1:0] HILO_SEL_MUL = 2'd1;
    localparam logic [1:0] HILO_SEL_RS  = 2'd2;

    function automatic logic op_is_div(input op_type_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_type_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/pipe_lat_counter.sv
// Loadable down-counter that times the latency of the multi-cycle unit.
// Ports:
//   i_clk, i_rst   - clock, asynchronous active-high reset
//   i_clear        - force the count to zero (takes priority over load)
//   i_load         - load i_load_val
//   i_load_val     - value loaded on i_load
//   o_zero         - count is zero
// The count decrements by one each cycle while non-zero and saturates at 0.
module pipe_lat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Count register: clear, load, or decrement toward zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clear) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != {CNT_W{1'b0}}) begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/pipe_muldiv_ctrl.sv
// EX-stage controller for the multi-cycle MULT/MULTU/DIV/DIVU units.
// Accepts one op, launches the unit, times its latency and schedules the
// HI/LO write-back; stalls the pipe while a result is in flight.
// Ports:
//   i_clk, i_rst        - clock, asynchronous active-high reset
//   i_op_valid          - EX holds a mul/div op
//   i_op_type           - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_hilo_read         - MFHI/MFLO in EX needs HI/LO
//   i_flush             - abort any in-flight op
//   o_op_ready          - controller idle, can accept an op
//   o_stall             - freeze IF/ID/EX
//   o_busy              - an op is in flight (RUN or DONE)
//   o_mul_start/o_div_start - one-cycle unit launch pulses
//   o_unit_signed       - signed op, latched at accept
//   o_hi_wena/o_lo_wena - HI/LO write enables (DONE cycle)
//   o_hi_mux_sel/o_lo_mux_sel - write-back source, latched at accept
module pipe_muldiv_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_op_valid,
    input  logic [1:0] i_op_type,
    input  logic       i_hilo_read,
    input  logic       i_flush,
    output logic       o_op_ready,
    output logic       o_stall,
    output logic       o_busy,
    output logic       o_mul_start,
    output logic       o_div_start,
    output logic       o_unit_signed,
    output logic       o_hi_wena,
    output logic       o_lo_wena,
    output logic [1:0] o_hi_mux_sel,
    output logic [1:0] o_lo_mux_sel
);

    // The counter is loaded with LAT-1 so RUN spans exactly LAT cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_e           r_state;
    state_e           w_state_nx;
    logic             r_first;
    logic             r_is_div;
    logic             r_signed;
    logic [1:0]       r_hi_sel;
    logic [1:0]       r_lo_sel;
    logic             w_accept;
    logic             w_zero;
    logic             w_new_div;
    logic [CNT_W-1:0] w_load_val;
    op_type_e         w_op;

    assign w_op       = op_type_e'(i_op_type);
    assign w_new_div  = op_is_div(w_op);
    assign w_load_val = w_new_div ? DIV_LOAD : MUL_LOAD;

    pipe_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (i_flush),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Op attributes captured at accept; r_first marks the first RUN cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_first  <= 1'b0;
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_hi_sel <= HILO_SEL_DIV;
            r_lo_sel <= HILO_SEL_DIV;
        end else begin
            r_first <= w_accept;
            if (w_accept) begin
                r_is_div <= w_new_div;
                r_signed <= op_is_signed(w_op);
                r_hi_sel <= w_new_div ? HILO_SEL_DIV : HILO_SEL_MUL;
                r_lo_sel <= w_new_div ? HILO_SEL_DIV : HILO_SEL_MUL;
            end
        end
    end

    // Next-state and pulse outputs. Flush always returns to IDLE; the start
    // pulse is not gated by flush since the unit result is simply dropped.
    always_comb begin
        w_state_nx  = r_state;
        w_accept    = 1'b0;
        o_mul_start = 1'b0;
        o_div_start = 1'b0;
        o_hi_wena   = 1'b0;
        o_lo_wena   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_flush) begin
                    w_state_nx = ST_IDLE;
                end else if (i_op_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = ST_RUN;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                o_mul_start = r_first & ~r_is_div;
                o_div_start = r_first & r_is_div;
                if (i_flush) begin
                    w_state_nx = ST_IDLE;
                end else if (w_zero) begin
                    w_state_nx = ST_DONE;
                end else begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_DONE: begin
                o_hi_wena  = ~i_flush;
                o_lo_wena  = ~i_flush;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign o_op_ready    = (r_state == ST_IDLE);
    assign o_busy        = (r_state != ST_IDLE);
    // No HI/LO forwarding, so DONE still stalls an MFHI/MFLO.
    assign o_stall       = o_busy & (i_op_valid | i_hilo_read);
    assign o_unit_signed = r_signed;
    assign o_hi_mux_sel  = r_hi_sel;
    assign o_lo_mux_sel  = r_lo_sel;

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
module tb_pipe_muldiv_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 33;
    localparam logic [11:0] RST_VEC = 12'b1000_0000_0000;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [1:0] op_type;
    logic       hilo_read;
    logic       flush;
    logic       op_ready, stall, busy, mul_start, div_start, unit_signed;
    logic       hi_wena, lo_wena;
    logic [1:0] hi_mux_sel, lo_mux_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
    } wb_t;

    wb_t sb[$];
    wb_t mon_e;

    pipe_muldiv_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (6)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_op_valid    (op_valid),
        .i_op_type     (op_type),
        .i_hilo_read   (hilo_read),
        .i_flush       (flush),
        .o_op_ready    (op_ready),
        .o_stall       (stall),
        .o_busy        (busy),
        .o_mul_start   (mul_start),
        .o_div_start   (div_start),
        .o_unit_signed (unit_signed),
        .o_hi_wena     (hi_wena),
        .o_lo_wena     (lo_wena),
        .o_hi_mux_sel  (hi_mux_sel),
        .o_lo_mux_sel  (lo_mux_sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] out_vec();
        return {op_ready, stall, busy, mul_start, div_start, unit_signed,
                hi_wena, lo_wena, hi_mux_sel, lo_mux_sel};
    endfunction

    // Write-back scoreboard: every write enable must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_missing: no write enable seen, required at cycle %0d (now %0d)", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (hi_wena || lo_wena) begin
                n_tests++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    n_fail++;
                    $display("FAIL wb_unexpected: write enable hi=%0b lo=%0b at cycle %0d, none required", hi_wena, lo_wena, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if ({hi_wena, lo_wena, hi_mux_sel, lo_mux_sel} !== {2'b11, mon_e.sel, mon_e.sel}) begin
                        n_fail++;
                        $display("FAIL wb_fields: got wena=%b%b sel=%0d/%0d, required 11 sel=%0d/%0d at cycle %0d",
                                 hi_wena, lo_wena, hi_mux_sel, lo_mux_sel, mon_e.sel, mon_e.sel, cyc);
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_missing: no write enable at cycle %0d", cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wb(input int c, input logic [1:0] s);
        wb_t t;
        t.cyc = c;
        t.sel = s;
        sb.push_back(t);
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; op_type = 2'b00; hilo_read = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required %b", out_vec(), RST_VEC);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_mult();
        int c0;
        logic e_ms, e_busy;
        c0 = cyc;
        op_valid = 1'b1; op_type = 2'b00;
        push_wb(c0 + MUL_LAT + 1, 2'b01);
        @(negedge clk);
        n_tests++;
        if ({op_ready, stall} !== 2'b10) begin
            n_fail++;
            $display("FAIL mult_accept: ready/stall %b, required 10", {op_ready, stall});
        end
        next_cycle();
        op_valid = 1'b0;
        for (int k = 1; k <= MUL_LAT + 2; k++) begin
            @(negedge clk);
            e_ms = (k == 1);
            e_busy = (k <= MUL_LAT + 1);
            n_tests++;
            if ({mul_start, div_start, busy} !== {e_ms, 1'b0, e_busy}) begin
                n_fail++;
                $display("FAIL mult_cycle%0d: mul/div/busy %b, required %b", k, {mul_start, div_start, busy}, {e_ms, 1'b0, e_busy});
            end
            if (k == 1) begin
                n_tests++;
                if ({unit_signed, hi_mux_sel, lo_mux_sel} !== 5'b1_01_01) begin
                    n_fail++;
                    $display("FAIL mult_attr: signed/sels %b, required 10101", {unit_signed, hi_mux_sel, lo_mux_sel});
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_divu();
        int c0;
        logic e_ds, e_busy;
        c0 = cyc;
        op_valid = 1'b1; op_type = 2'b11;
        push_wb(c0 + DIV_LAT + 1, 2'b00);
        next_cycle();
        op_valid = 1'b0;
        for (int k = 1; k <= DIV_LAT + 2; k++) begin
            @(negedge clk);
            e_ds = (k == 1);
            e_busy = (k <= DIV_LAT + 1);
            n_tests++;
            if ({mul_start, div_start, busy, op_ready} !== {1'b0, e_ds, e_busy, ~e_busy}) begin
                n_fail++;
                $display("FAIL divu_cycle%0d: mul/div/busy/ready %b, required %b", k,
                         {mul_start, div_start, busy, op_ready}, {1'b0, e_ds, e_busy, ~e_busy});
            end
            if (k == 1) begin
                n_tests++;
                if ({unit_signed, hi_mux_sel, lo_mux_sel} !== 5'b0_00_00) begin
                    n_fail++;
                    $display("FAIL divu_attr: signed/sels %b, required 00000", {unit_signed, hi_mux_sel, lo_mux_sel});
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_mflo_stall();
        int c0;
        logic e_st;
        c0 = cyc;
        op_valid = 1'b1; op_type = 2'b00;
        push_wb(c0 + MUL_LAT + 1, 2'b01);
        next_cycle();
        op_valid = 1'b0;
        for (int k = 1; k <= MUL_LAT + 2; k++) begin
            hilo_read = (k >= 2);
            @(negedge clk);
            e_st = (k >= 2) && (k <= MUL_LAT + 1);
            n_tests++;
            if (stall !== e_st) begin
                n_fail++;
                $display("FAIL mflo_stall_cycle%0d: stall %b, required %b", k, stall, e_st);
            end
            next_cycle();
        end
        hilo_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        int c0;
        logic e_busy, e_st, e_ms, e_ds, e_sg;
        logic [1:0] e_sel;
        c0 = cyc;
        op_valid = 1'b1; op_type = 2'b10;
        push_wb(c0 + DIV_LAT + 1, 2'b00);
        push_wb(c0 + DIV_LAT + 2 + MUL_LAT + 1, 2'b01);
        next_cycle();
        for (int k = 1; k <= DIV_LAT + MUL_LAT + 4; k++) begin
            op_type  = 2'b01;
            op_valid = (k <= DIV_LAT + 2);
            @(negedge clk);
            e_busy = (k <= DIV_LAT + 1) || (k >= DIV_LAT + 3 && k <= DIV_LAT + MUL_LAT + 3);
            e_st   = e_busy && (k <= DIV_LAT + 2);
            e_ds   = (k == 1);
            e_ms   = (k == DIV_LAT + 3);
            e_sg   = (k <= DIV_LAT + 2);
            e_sel  = (k <= DIV_LAT + 2) ? 2'b00 : 2'b01;
            n_tests++;
            if ({busy, stall, op_ready, mul_start, div_start, unit_signed, hi_mux_sel, lo_mux_sel} !==
                {e_busy, e_st, ~e_busy, e_ms, e_ds, e_sg, e_sel, e_sel}) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: busy/stall/ready/ms/ds/sg/sels %b, required %b", k,
                         {busy, stall, op_ready, mul_start, div_start, unit_signed, hi_mux_sel, lo_mux_sel},
                         {e_busy, e_st, ~e_busy, e_ms, e_ds, e_sg, e_sel, e_sel});
            end
            next_cycle();
        end
        op_valid = 1'b0;
    endtask

    task automatic test_flush_run();
        logic e_busy;
        op_valid = 1'b1; op_type = 2'b10;
        next_cycle();
        op_valid = 1'b0;
        for (int k = 1; k <= DIV_LAT + 4; k++) begin
            flush    = (k == 10) || (k == 12);
            op_valid = (k == 12);
            @(negedge clk);
            e_busy = (k <= 10);
            n_tests++;
            if ({busy, op_ready, hi_wena, lo_wena} !== {e_busy, ~e_busy, 2'b00}) begin
                n_fail++;
                $display("FAIL flush_run_cycle%0d: busy/ready/wena %b, required %b", k,
                         {busy, op_ready, hi_wena, lo_wena}, {e_busy, ~e_busy, 2'b00});
            end
            next_cycle();
        end
        flush = 1'b0; op_valid = 1'b0;
    endtask

    task automatic test_flush_first_run();
        op_valid = 1'b1; op_type = 2'b00;
        next_cycle();
        op_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({mul_start, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_first_run: start/busy %b, required 11", {mul_start, busy});
        end
        next_cycle();
        flush = 1'b0;
        for (int k = 2; k <= MUL_LAT + 3; k++) begin
            @(negedge clk);
            n_tests++;
            if ({busy, mul_start, hi_wena} !== 3'b000) begin
                n_fail++;
                $display("FAIL flush_first_after%0d: busy/start/wena %b, required 000", k, {busy, mul_start, hi_wena});
            end
            next_cycle();
        end
    endtask

    task automatic test_flush_done();
        op_valid = 1'b1; op_type = 2'b01;
        next_cycle();
        op_valid = 1'b0;
        for (int k = 1; k <= MUL_LAT + 2; k++) begin
            flush = (k == MUL_LAT + 1);
            @(negedge clk);
            n_tests++;
            if ({busy, hi_wena, lo_wena} !== {(k <= MUL_LAT + 1), 2'b00}) begin
                n_fail++;
                $display("FAIL flush_done_cycle%0d: busy/wena %b, required %b", k,
                         {busy, hi_wena, lo_wena}, {(k <= MUL_LAT + 1), 2'b00});
            end
            next_cycle();
        end
        flush = 1'b0;
    endtask

    task automatic test_rst_mid_run();
        op_valid = 1'b1; op_type = 2'b00;
        next_cycle();
        op_valid = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL rst_mid_run: outputs %b, required %b", out_vec(), RST_VEC);
        end
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < MUL_LAT + 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (out_vec() !== RST_VEC) begin
                n_fail++;
                $display("FAIL rst_after%0d: outputs %b, required %b", k, out_vec(), RST_VEC);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu();
        test_mflo_stall();
        test_back_to_back();
        test_flush_run();
        test_flush_first_run();
        test_flush_done();
        test_rst_mid_run();
        repeat (3) next_cycle();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d write-backs outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
